// File: rtl/whack_game_if.sv
// Signal bundle between the whack-a-mole round sequencer and its surroundings:
// keypad/random inputs on one side, display-facing state on the other.
interface whack_game_if;
    logic       start;
    logic       key_valid;
    logic [3:0] key_val;
    logic [3:0] rnd;
    logic [3:0] mole_pos;
    logic       mole_vis;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic       game_over;
    logic [2:0] fsm_state;

    modport master (
        output start, key_valid, key_val, rnd,
        input  mole_pos, mole_vis, time_tens, time_ones,
               score_tens, score_ones, game_over, fsm_state
    );

    modport slave (
        input  start, key_valid, key_val, rnd,
        output mole_pos, mole_vis, time_tens, time_ones,
               score_tens, score_ones, game_over, fsm_state
    );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole round sequencer: mole spawn/dwell/hit FSM with a BCD countdown
// timer and a saturating BCD score, all outputs registered.
module whack_game_ctrl #(
    parameter int SEC_CYCLES   = 50000000,
    parameter int MOLE_CYCLES  = 25000000,
    parameter int GAP_CYCLES   = 5000000,
    parameter int GAME_SECONDS = 30
) (
    input  logic         clk,
    input  logic         rst,
    whack_game_if.slave  bus
);
    localparam int SEC_W  = (SEC_CYCLES  > 1) ? $clog2(SEC_CYCLES)  : 1;
    localparam int DWL_W  = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
    localparam logic [7:0] GAME_BCD = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        UP    = 3'd2,
        HIT   = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [SEC_W-1:0] sec_cnt;
    logic [DWL_W-1:0] dwell_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       mole_pos;
    logic             mole_vis;
    logic [7:0]       time_bcd;
    logic [7:0]       score_bcd;
    logic             game_over;

    logic active, sec_tick, final_tick, hit, dwell_done, gap_done;
    logic [3:0] spawn_pos;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)      return v;
        if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_next = state;
        active     = (state == SPAWN) || (state == UP) || (state == HIT);
        sec_tick   = active && (sec_cnt == SEC_W'(SEC_CYCLES - 1));
        final_tick = sec_tick && (time_bcd == 8'h01);
        hit        = (state == UP) && bus.key_valid && (bus.key_val == mole_pos);
        dwell_done = (dwell_cnt == DWL_W'(MOLE_CYCLES - 1));
        gap_done   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
        // Never reuse the previous hole back to back.
        spawn_pos  = (bus.rnd == mole_pos) ? bus.rnd + 4'd1 : bus.rnd;

        case (state)
            IDLE, OVER: if (bus.start) state_next = SPAWN;
            SPAWN:      state_next = UP;
            UP: begin
                if (hit)             state_next = HIT;
                else if (dwell_done) state_next = SPAWN;
            end
            HIT:        if (gap_done) state_next = SPAWN;
            default:    state_next = IDLE;
        endcase
        // Running out of time beats every other transition.
        if (final_tick) state_next = OVER;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt   <= '0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            mole_pos  <= 4'd0;
            mole_vis  <= 1'b0;
            time_bcd  <= GAME_BCD;
            score_bcd <= 8'h00;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (bus.start) begin
                        score_bcd <= 8'h00;
                        time_bcd  <= GAME_BCD;
                        sec_cnt   <= '0;
                        game_over <= 1'b0;
                    end
                end
                SPAWN: begin
                    if (!final_tick) begin
                        mole_pos  <= spawn_pos;
                        mole_vis  <= 1'b1;
                        dwell_cnt <= '0;
                    end
                end
                UP: begin
                    if (hit) begin
                        mole_vis  <= 1'b0;
                        score_bcd <= bcd_inc_sat(score_bcd);
                        gap_cnt   <= '0;
                    end else if (dwell_done) begin
                        mole_vis  <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWL_W'(1);
                    end
                end
                HIT: begin
                    if (!gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase

            if (active) begin
                if (sec_tick) begin
                    sec_cnt  <= '0;
                    time_bcd <= bcd_dec(time_bcd);
                end else begin
                    sec_cnt  <= sec_cnt + SEC_W'(1);
                end
            end

            if (final_tick) begin
                mole_vis  <= 1'b0;
                game_over <= 1'b1;
            end
        end
    end

    assign bus.mole_pos   = mole_pos;
    assign bus.mole_vis   = mole_vis;
    assign bus.time_tens  = time_bcd[7:4];
    assign bus.time_ones  = time_bcd[3:0];
    assign bus.score_tens = score_bcd[7:4];
    assign bus.score_ones = score_bcd[3:0];
    assign bus.game_over  = game_over;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: a table of per-cycle vectors plus hand-built round,
// final-second and score-saturation sequences, checked through a scoreboard queue.
module tb_whack_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    whack_game_if bus();
    whack_game_if sbus();

    whack_game_ctrl #(.SEC_CYCLES(10), .MOLE_CYCLES(4), .GAP_CYCLES(2), .GAME_SECONDS(3))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Long-round instance used only to drive the score past 99.
    whack_game_ctrl #(.SEC_CYCLES(1000), .MOLE_CYCLES(4), .GAP_CYCLES(2), .GAME_SECONDS(99))
        u_sat (.clk(clk), .rst(srst), .bus(sbus));

    localparam logic [24:0] FULL  = 25'h1FFFFFF;
    localparam logic [24:0] M_ST  = 25'h1C00000;
    localparam logic [24:0] M_VIS = 25'h0200000;
    localparam logic [24:0] M_POS = 25'h01E0000;
    localparam logic [24:0] M_TM  = 25'h001FE00;
    localparam logic [24:0] M_SC  = 25'h00001FE;
    localparam logic [24:0] M_GO  = 25'h0000001;

    typedef struct packed {
        logic        r;
        logic        s;
        logic        kv;
        logic [3:0]  kval;
        logic [3:0]  rnd;
        logic [24:0] exp;
    } vec_t;

    vec_t        vecs [23];
    logic [24:0] exp_q  [$];
    logic [24:0] mask_q [$];
    string       name_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [24:0] pk(input logic [2:0] st, input logic vis, input logic [3:0] pos,
                                       input logic [7:0] tm, input logic [7:0] sc, input logic go);
        return {st, vis, pos, tm, sc, go};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic kv, input logic [3:0] kval,
                                input logic [3:0] rnd, input logic [24:0] e);
        return {r, s, kv, kval, rnd, e};
    endfunction

    function automatic logic [24:0] obs(input bit which);
        if (which)
            return {sbus.fsm_state, sbus.mole_vis, sbus.mole_pos, sbus.time_tens, sbus.time_ones,
                    sbus.score_tens, sbus.score_ones, sbus.game_over};
        return {bus.fsm_state, bus.mole_vis, bus.mole_pos, bus.time_tens, bus.time_ones,
                bus.score_tens, bus.score_ones, bus.game_over};
    endfunction

    function automatic logic [7:0] tm_of(input int k);
        if (k < 10) return 8'h03;
        if (k < 20) return 8'h02;
        return 8'h01;
    endfunction

    task automatic check(input bit which);
        logic [24:0] e, m, a;
        string nm;
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        nm = name_q.pop_front();
        a = obs(which);
        n_checks++;
        if (((a ^ e) & m) != 25'd0) begin
            n_fail++;
            $display("FAIL %s: got st=%0d vis=%0d pos=%0d time=%h score=%h go=%0d, expected st=%0d vis=%0d pos=%0d time=%h score=%h go=%0d (mask %h)",
                     nm, a[24:22], a[21], a[20:17], a[16:9], a[8:1], a[0],
                     e[24:22], e[21], e[20:17], e[16:9], e[8:1], e[0], m);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge.
    task automatic step(input bit which, input logic r, input logic s, input logic kv,
                        input logic [3:0] kval, input logic [3:0] rnd,
                        input logic [24:0] e, input logic [24:0] m, input string nm);
        if (which) begin
            srst = r; sbus.start = s; sbus.key_valid = kv; sbus.key_val = kval; sbus.rnd = rnd;
            rst = 1'b0; bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_val = 4'd0; bus.rnd = 4'd0;
        end else begin
            rst = r; bus.start = s; bus.key_valid = kv; bus.key_val = kval; bus.rnd = rnd;
        end
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check(which);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [7:0] sc;
        int n;
        bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_val = 4'd0; bus.rnd = 4'd0;
        sbus.start = 1'b0; sbus.key_valid = 1'b0; sbus.key_val = 4'd0; sbus.rnd = 4'd0;

        // rst, start, key_valid, key_val, rnd ; state, vis, pos, time, score, game_over
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  pk(3'd0, 1'b0, 4'd0,  8'h03, 8'h00, 1'b0));
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd5,  pk(3'd0, 1'b0, 4'd0,  8'h03, 8'h00, 1'b0));
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd5,  pk(3'd1, 1'b0, 4'd0,  8'h03, 8'h00, 1'b0));
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd5,  pk(3'd2, 1'b1, 4'd5,  8'h03, 8'h00, 1'b0));
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd5,  pk(3'd2, 1'b1, 4'd5,  8'h03, 8'h00, 1'b0));
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 4'd4, 4'd5,  pk(3'd2, 1'b1, 4'd5,  8'h03, 8'h00, 1'b0));
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd5,  pk(3'd2, 1'b1, 4'd5,  8'h03, 8'h00, 1'b0));
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd5,  pk(3'd1, 1'b0, 4'd5,  8'h03, 8'h00, 1'b0));
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd5,  pk(3'd2, 1'b1, 4'd6,  8'h03, 8'h00, 1'b0));
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'd6, 4'd5,  pk(3'd3, 1'b0, 4'd6,  8'h03, 8'h01, 1'b0));
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 4'd6, 4'd15, pk(3'd3, 1'b0, 4'd6,  8'h03, 8'h01, 1'b0));
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd1, 1'b0, 4'd6,  8'h03, 8'h01, 1'b0));
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd2, 1'b1, 4'd15, 8'h02, 8'h01, 1'b0));
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd2, 1'b1, 4'd15, 8'h02, 8'h01, 1'b0));
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd2, 1'b1, 4'd15, 8'h02, 8'h01, 1'b0));
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd2, 1'b1, 4'd15, 8'h02, 8'h01, 1'b0));
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd1, 1'b0, 4'd15, 8'h02, 8'h01, 1'b0));
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, pk(3'd2, 1'b1, 4'd0,  8'h02, 8'h01, 1'b0));
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd9,  pk(3'd3, 1'b0, 4'd0,  8'h02, 8'h02, 1'b0));
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  pk(3'd3, 1'b0, 4'd0,  8'h02, 8'h02, 1'b0));
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  pk(3'd1, 1'b0, 4'd0,  8'h02, 8'h02, 1'b0));
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  pk(3'd2, 1'b1, 4'd9,  8'h02, 8'h02, 1'b0));
        vecs[22] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd9,  pk(3'd0, 1'b0, 4'd0,  8'h03, 8'h00, 1'b0));

        @(negedge clk);
        for (int i = 0; i < 23; i++)
            step(1'b0, vecs[i].r, vecs[i].s, vecs[i].kv, vecs[i].kval, vecs[i].rnd,
                 vecs[i].exp, FULL, $sformatf("vec%0d", i));

        // Uninterrupted round: spawns with rnd=3 alternate 3,4,... so the last mole is at 4.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, pk(3'd1, 1'b0, 4'd0, 8'h03, 8'h00, 1'b0), FULL, "round_start");
        for (int k = 1; k < 30; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, pk(3'd0, 1'b0, 4'd0, tm_of(k), 8'h00, 1'b0),
                 M_TM | M_GO, $sformatf("round_timer_k%0d", k));
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, pk(3'd4, 1'b0, 4'd4, 8'h00, 8'h00, 1'b1), FULL, "round_over");
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd3, pk(3'd4, 1'b0, 4'd4, 8'h00, 8'h00, 1'b1),
                 FULL, $sformatf("over_hold%0d", k));

        // Restart from OVER; spawns with rnd=8 give 8,9,8,9,8,9, then hit on the final-second edge.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, pk(3'd1, 1'b0, 4'd4, 8'h03, 8'h00, 1'b0), FULL, "restart_from_over");
        for (int k = 1; k < 29; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, pk(3'd0, 1'b0, 4'd0, tm_of(k), 8'h00, 1'b0),
                 M_TM | M_SC, $sformatf("round2_timer_k%0d", k));
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, pk(3'd2, 1'b1, 4'd9, 8'h01, 8'h00, 1'b0), FULL, "before_final_hit");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd8, pk(3'd4, 1'b0, 4'd9, 8'h00, 8'h01, 1'b1), FULL, "hit_on_final_tick");

        // Score carry and saturation on the long-round instance.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, pk(3'd0, 1'b0, 4'd0, 8'h99, 8'h00, 1'b0), FULL, "sat_reset");
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, pk(3'd1, 1'b0, 4'd0, 8'h99, 8'h00, 1'b0), FULL, "sat_start");
        for (int i = 0; i < 101; i++) begin
            r  = (i % 2 == 1) ? 4'd2 : 4'd11;
            n  = (i + 1 > 99) ? 99 : i + 1;
            sc = {4'(n / 10), 4'(n % 10)};
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, r, pk(3'd2, 1'b1, r, 8'h00, 8'h00, 1'b0),
                 M_ST | M_VIS | M_POS, $sformatf("sat_up%0d", i));
            step(1'b1, 1'b0, 1'b0, 1'b1, r, r, pk(3'd3, 1'b0, 4'd0, 8'h00, sc, 1'b0),
                 M_ST | M_VIS | M_SC | M_GO, $sformatf("sat_hit%0d", i));
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, r, pk(3'd3, 1'b0, 4'd0, 8'h00, sc, 1'b0),
                 M_ST | M_SC, $sformatf("sat_gap%0d", i));
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, r, pk(3'd1, 1'b0, 4'd0, 8'h00, sc, 1'b0),
                 M_ST | M_SC, $sformatf("sat_spawn%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
